// File: rtl/spi_peripheral_if.sv
// SPI bus bundle between a master driver and a peripheral endpoint.
// Port names keep the SPI_* naming used on the link itself.
interface spi_peripheral_if;
  logic SPI_CLK;
  logic SPI_MOSI;
  logic SPI_EN;
  logic SPI_MISO;

  modport master (
    output SPI_CLK,
    output SPI_MOSI,
    output SPI_EN,
    input  SPI_MISO
  );

  modport slave (
    input  SPI_CLK,
    input  SPI_MOSI,
    input  SPI_EN,
    output SPI_MISO
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint. Oversamples SPI_CLK/SPI_MOSI/SPI_EN on clk,
// deserialises MOSI MSB-first into data_out and serialises a buffered
// transmit byte onto MISO. Multiple bytes per select window are supported.
// CPOL/CPHA must match the master's mode.
module spi_peripheral #(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  spi_peripheral_if.slave spi,
  input  logic [7:0]      data_in,
  input  logic            tx_load,
  output logic            tx_ready,
  output logic [7:0]      data_out,
  output logic            rx_valid,
  output logic            tx_underrun,
  output logic            busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Synchroniser bit positions: {EN, MOSI, CLK}
  localparam int SYNC_CLK  = 0;
  localparam int SYNC_MOSI = 1;
  localparam int SYNC_EN   = 2;

  // Pin synchronisers and edge history
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic       sclk_prev_reg;
  logic       en_prev_reg;

  // Protocol state
  logic [0:0] state_reg,     state_next;
  logic [2:0] bit_cnt_reg,   bit_cnt_next;
  logic       byte_done_reg, byte_done_next;
  logic [7:0] rx_shift_reg,  rx_shift_next;
  logic [7:0] data_out_reg,  data_out_next;
  logic       rx_valid_reg,  rx_valid_next;

  // Transmit path
  logic [7:0] tx_shift_reg,   tx_shift_next;
  logic [7:0] tx_buf_reg,     tx_buf_next;
  logic       tx_pending_reg, tx_pending_next;
  logic       underrun_reg,   underrun_next;

  // Requests from the protocol FSM to the transmit path
  logic reload_req;
  logic shift_req;

  // Decoded edges of the synchronised pins
  logic sclk_sync;
  logic mosi_sync;
  logic en_sync;
  logic sclk_rise;
  logic sclk_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic en_rise;

  assign sclk_sync = sync2_reg[SYNC_CLK];
  assign mosi_sync = sync2_reg[SYNC_MOSI];
  assign en_sync   = sync2_reg[SYNC_EN];

  assign sclk_rise = sclk_sync & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync & sclk_prev_reg;

  // Leading edge leaves the idle level, trailing edge returns to it
  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;

  // CPHA picks which edge samples MOSI; the other one advances MISO
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  assign en_rise = en_sync & ~en_prev_reg;

  // Two-flop synchronisers plus the previous-value register used for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg     <= 3'b000;
      sync2_reg     <= 3'b000;
      sclk_prev_reg <= 1'b0;
      en_prev_reg   <= 1'b0;
    end else begin
      sync1_reg     <= {spi.SPI_EN, spi.SPI_MOSI, spi.SPI_CLK};
      sync2_reg     <= sync1_reg;
      sclk_prev_reg <= sclk_sync;
      en_prev_reg   <= en_sync;
    end
  end

  // Protocol FSM: select handling, MOSI deserialisation, shift/reload requests
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_done_next = byte_done_reg;
    rx_shift_next  = rx_shift_reg;
    data_out_next  = data_out_reg;
    rx_valid_next  = 1'b0;
    reload_req     = 1'b0;
    shift_req      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Clock edges are ignored here and in the select cycle itself
        if (en_rise) begin
          reload_req     = 1'b1;
          bit_cnt_next   = 3'd0;
          byte_done_next = 1'b0;
          state_next     = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (!en_sync) begin
          // Deselect drops any partial byte silently
          state_next     = ST_IDLE;
          bit_cnt_next   = 3'd0;
          byte_done_next = 1'b0;
          rx_shift_next  = 8'h00;
        end else if (sample_edge) begin
          rx_shift_next = {rx_shift_reg[6:0], mosi_sync};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            data_out_next  = {rx_shift_reg[6:0], mosi_sync};
            rx_valid_next  = 1'b1;
            byte_done_next = 1'b1;
          end
        end else if (shift_edge) begin
          if (bit_cnt_reg != 3'd0) begin
            shift_req = 1'b1;
          end else if (byte_done_reg) begin
            // First shift edge after a completed byte starts the next one
            reload_req     = 1'b1;
            byte_done_next = 1'b0;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Transmit path: TX buffer, reload into the shifter, MISO shifting
  always_comb begin
    tx_shift_next   = tx_shift_reg;
    tx_buf_next     = tx_buf_reg;
    tx_pending_next = tx_pending_reg;
    underrun_next   = 1'b0;

    if (reload_req) begin
      if (tx_pending_reg) begin
        tx_shift_next   = tx_buf_reg;
        tx_pending_next = 1'b0;
      end else begin
        tx_shift_next = 8'h00;
        underrun_next = 1'b1;
      end
    end else if (shift_req) begin
      tx_shift_next = {tx_shift_reg[6:0], 1'b0};
    end

    // A load in the same cycle as a reload lands after the reload sampled
    // the buffer, so it serves the following reload instead.
    if (tx_load && !tx_pending_reg) begin
      tx_buf_next     = data_in;
      tx_pending_next = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      byte_done_reg  <= 1'b0;
      rx_shift_reg   <= 8'h00;
      data_out_reg   <= 8'h00;
      rx_valid_reg   <= 1'b0;
      tx_shift_reg   <= 8'h00;
      tx_buf_reg     <= 8'h00;
      tx_pending_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_done_reg  <= byte_done_next;
      rx_shift_reg   <= rx_shift_next;
      data_out_reg   <= data_out_next;
      rx_valid_reg   <= rx_valid_next;
      tx_shift_reg   <= tx_shift_next;
      tx_buf_reg     <= tx_buf_next;
      tx_pending_reg <= tx_pending_next;
      underrun_reg   <= underrun_next;
    end
  end

  assign busy         = (state_reg == ST_ACTIVE);
  assign tx_ready     = ~tx_pending_reg;
  assign data_out     = data_out_reg;
  assign rx_valid     = rx_valid_reg;
  assign tx_underrun  = underrun_reg;
  assign spi.SPI_MISO = busy & tx_shift_reg[7];

endmodule

// File: tb/tb_spi_peripheral.sv
// Testbench for spi_peripheral: a mode-0 and a mode-3 instance driven by a
// behavioural SPI master, with a transaction-level model of the TX buffer
// and a per-cycle checker of the receive side.
module tb_spi_peripheral;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;

  // Pin drives per instance (0: CPOL=0/CPHA=0, 1: CPOL=1/CPHA=1)
  logic       p_clk [2];
  logic       p_mosi[2];
  logic       p_en  [2];
  logic [7:0] din   [2];
  logic       ld    [2];
  logic       tx_ready[2];
  logic       rx_valid[2];
  logic       under   [2];
  logic       busy    [2];
  logic [7:0] dout    [2];
  logic       miso    [2];

  spi_peripheral_if bus0();
  spi_peripheral_if bus1();

  assign bus0.SPI_CLK  = p_clk[0];
  assign bus0.SPI_MOSI = p_mosi[0];
  assign bus0.SPI_EN   = p_en[0];
  assign bus1.SPI_CLK  = p_clk[1];
  assign bus1.SPI_MOSI = p_mosi[1];
  assign bus1.SPI_EN   = p_en[1];
  assign miso[0] = bus0.SPI_MISO;
  assign miso[1] = bus1.SPI_MISO;

  spi_peripheral #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .spi(bus0),
    .data_in(din[0]), .tx_load(ld[0]), .tx_ready(tx_ready[0]),
    .data_out(dout[0]), .rx_valid(rx_valid[0]),
    .tx_underrun(under[0]), .busy(busy[0])
  );

  spi_peripheral #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .spi(bus1),
    .data_in(din[1]), .tx_load(ld[1]), .tx_ready(tx_ready[1]),
    .data_out(dout[1]), .rx_valid(rx_valid[1]),
    .tx_underrun(under[1]), .busy(busy[1])
  );

  int errors = 0;
  int checks = 0;

  // Model state
  logic [7:0] m_buf[2];
  bit         m_pending[2];
  int         exp_under[2];
  int         act_under[2];
  logic [7:0] last_rx[2];
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];

  // Per-transfer plan
  logic [7:0] plan_rx[4];
  logic [7:0] plan_tx[4];
  bit         plan_ld[4];
  logic [7:0] rcv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receive-side checker: every cycle, data_out either holds or takes the
  // next byte the master sent, exactly when rx_valid is pulsed.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_q) begin
        check("reset_rx_valid", 32'(rx_valid[d]), 32'd0);
        check("reset_data_out", 32'(dout[d]), 32'd0);
        last_rx[d] = 8'h00;
        if (d == 0) rxq0.delete(); else rxq1.delete();
      end else begin
        if (under[d] === 1'b1) act_under[d]++;
        if (rx_valid[d] === 1'b1) begin
          if ((d == 0 ? rxq0.size() : rxq1.size()) == 0) begin
            check("rx_valid_unexpected", 32'(rx_valid[d]), 32'd0);
          end else begin
            logic [7:0] e;
            if (d == 0) e = rxq0.pop_front(); else e = rxq1.pop_front();
            check("rx_data", 32'(dout[d]), 32'(e));
            last_rx[d] = e;
          end
        end else begin
          check("data_out_hold", 32'(dout[d]), 32'(last_rx[d]));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_rx(input int d, input logic [7:0] v);
    if (d == 0) rxq0.push_back(v); else rxq1.push_back(v);
  endtask

  // Reload as seen from outside: take the buffered byte, or 0x00 and an underrun
  task automatic m_reload(input int d, output logic [7:0] v);
    if (m_pending[d]) begin
      v = m_buf[d];
      m_pending[d] = 1'b0;
    end else begin
      v = 8'h00;
      exp_under[d]++;
    end
  endtask

  task automatic do_load(input int d, input logic [7:0] v);
    din[d] = v;
    ld[d] = 1'b1;
    @(negedge clk);
    ld[d] = 1'b0;
    if (!m_pending[d]) begin
      m_buf[d] = v;
      m_pending[d] = 1'b1;
    end
    check("tx_ready_after_load", 32'(tx_ready[d]), 32'd0);
  endtask

  task automatic phase_wait(input int d, input int k, input int i);
    if (i == 4 && plan_ld[k]) begin
      do_load(d, plan_tx[k]);
      wait_cyc(H - 1);
    end else begin
      wait_cyc(H);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < 4; k++) begin
      plan_rx[k] = 8'h00;
      plan_tx[k] = 8'h00;
      plan_ld[k] = 1'b0;
    end
  endtask

  // Full transfer of n bytes in one select window, as the master sees it
  task automatic xfer(input int d, input int n);
    logic [7:0] exp_tx[5];
    logic [7:0] got;
    bit pend0;
    int u0;
    bit cpol;
    bit cpha;
    cpol = (d == 1);
    cpha = (d == 1);
    pend0 = m_pending[d];
    u0 = act_under[d];
    p_en[d] = 1'b1;
    m_reload(d, exp_tx[0]);
    wait_cyc(2);
    check("tx_ready_before_reload", 32'(tx_ready[d]), 32'(!pend0));
    wait_cyc(1);
    check("tx_ready_after_select", 32'(tx_ready[d]), 32'd1);
    check("busy_after_select", 32'(busy[d]), 32'd1);
    check("miso_first_bit", 32'(miso[d]), 32'(exp_tx[0][7]));
    wait_cyc(1);
    check("underrun_at_select", 32'(act_under[d] - u0), pend0 ? 32'd0 : 32'd1);
    wait_cyc(2);
    for (int k = 0; k < n; k++) begin
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        if (!cpha) begin
          p_mosi[d] = plan_rx[k][i];
          wait_cyc(2);
          got[i] = miso[d];
          if (i == 0) push_rx(d, plan_rx[k]);
          p_clk[d] = !cpol;
          phase_wait(d, k, i);
          p_clk[d] = cpol;
          if (i == 0) m_reload(d, exp_tx[k + 1]);
          wait_cyc(H);
        end else begin
          if (i == 7 && k > 0) m_reload(d, exp_tx[k]);
          p_clk[d] = !cpol;
          p_mosi[d] = plan_rx[k][i];
          phase_wait(d, k, i);
          got[i] = miso[d];
          if (i == 0) push_rx(d, plan_rx[k]);
          p_clk[d] = cpol;
          wait_cyc(H);
        end
      end
      check("miso_byte", 32'(got), 32'(exp_tx[k]));
      rcv[k] = got;
    end
    wait_cyc(2);
    p_en[d] = 1'b0;
    wait_cyc(6);
    check("busy_after_deselect", 32'(busy[d]), 32'd0);
    check("miso_idle", 32'(miso[d]), 32'd0);
    check("rx_outstanding", 32'(d == 0 ? rxq0.size() : rxq1.size()), 32'd0);
    check("underrun_count", 32'(act_under[d]), 32'(exp_under[d]));
  endtask

  // Partial transfer of nbits, ended by deselect or by a reset pulse
  task automatic partial(input int d, input int nbits, input bit do_rst);
    logic [7:0] dummy;
    bit cpol;
    cpol = (d == 1);
    p_en[d] = 1'b1;
    m_reload(d, dummy);
    wait_cyc(6);
    check("busy_partial", 32'(busy[d]), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      p_mosi[d] = 1'($urandom_range(0, 1));
      wait_cyc(2);
      p_clk[d] = !cpol;
      wait_cyc(H);
      p_clk[d] = cpol;
      wait_cyc(H);
    end
    if (do_rst) begin
      rst = 1'b1;
      p_en[d] = 1'b0;
      p_mosi[d] = 1'b0;
      wait_cyc(1);
      check("rst_tx_ready", 32'(tx_ready[d]), 32'd1);
      check("rst_miso", 32'(miso[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_underrun", 32'(under[d]), 32'd0);
      check("rst_data_out", 32'(dout[d]), 32'd0);
      rst = 1'b0;
      m_pending[0] = 1'b0;
      m_pending[1] = 1'b0;
      wait_cyc(6);
    end else begin
      p_en[d] = 1'b0;
      wait_cyc(6);
      check("busy_early_deselect", 32'(busy[d]), 32'd0);
    end
    check("rx_outstanding_partial", 32'(d == 0 ? rxq0.size() : rxq1.size()), 32'd0);
    check("underrun_count_partial", 32'(act_under[d]), 32'(exp_under[d]));
  endtask

  initial begin
    int u0;
    p_clk[0] = 1'b0; p_clk[1] = 1'b1;
    p_mosi[0] = 1'b0; p_mosi[1] = 1'b0;
    p_en[0] = 1'b0; p_en[1] = 1'b0;
    din[0] = 8'h00; din[1] = 8'h00;
    ld[0] = 1'b0; ld[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_buf[d] = 8'h00; m_pending[d] = 1'b0;
      exp_under[d] = 0; act_under[d] = 0; last_rx[d] = 8'h00;
    end
    clear_plan();

    // Reset values
    wait_cyc(3);
    for (int d = 0; d < 2; d++) begin
      check("reset_tx_ready", 32'(tx_ready[d]), 32'd1);
      check("reset_miso", 32'(miso[d]), 32'd0);
      check("reset_busy", 32'(busy[d]), 32'd0);
      check("reset_underrun", 32'(under[d]), 32'd0);
    end
    rst = 1'b0;
    wait_cyc(4);

    // Mode 0: preload 0xA5, receive 0x3C
    clear_plan();
    plan_rx[0] = 8'h3C;
    do_load(0, 8'hA5);
    xfer(0, 1);
    check("mode0_master_rx", 32'(rcv[0]), 32'hA5);
    check("mode0_data_out", 32'(dout[0]), 32'h3C);

    // Two-byte burst, third byte loaded so the closing reload has data
    clear_plan();
    plan_rx[0] = 8'h11; plan_rx[1] = 8'h22;
    plan_ld[0] = 1'b1;  plan_tx[0] = 8'h5A;
    plan_ld[1] = 1'b1;  plan_tx[1] = 8'h33;
    do_load(0, 8'hA5);
    u0 = act_under[0];
    xfer(0, 2);
    check("burst_rx0", 32'(rcv[0]), 32'hA5);
    check("burst_rx1", 32'(rcv[1]), 32'h5A);
    check("burst_no_underrun", 32'(act_under[0] - u0), 32'd0);
    check("burst_data_out", 32'(dout[0]), 32'h22);

    // Empty TX buffer
    clear_plan();
    plan_rx[0] = 8'hFF;
    xfer(0, 1);
    check("empty_master_rx", 32'(rcv[0]), 32'h00);
    check("empty_data_out", 32'(dout[0]), 32'hFF);

    // Early deselect, then a full transfer
    partial(0, 5, 1'b0);
    check("deselect_data_out", 32'(dout[0]), 32'hFF);
    clear_plan();
    plan_rx[0] = 8'h96;
    xfer(0, 1);
    check("after_deselect_data_out", 32'(dout[0]), 32'h96);

    // Mode 3 instance
    clear_plan();
    plan_rx[0] = 8'h81;
    do_load(1, 8'hC3);
    xfer(1, 1);
    check("mode3_master_rx", 32'(rcv[0]), 32'hC3);
    check("mode3_data_out", 32'(dout[1]), 32'h81);

    // Reset in the middle of a byte, then a clean transfer
    do_load(0, 8'h4B);
    partial(0, 3, 1'b1);
    clear_plan();
    plan_rx[0] = 8'h69;
    do_load(0, 8'hE7);
    xfer(0, 1);
    check("post_reset_master_rx", 32'(rcv[0]), 32'hE7);
    check("post_reset_data_out", 32'(dout[0]), 32'h69);

    // Randomised transfers on both instances
    for (int t = 0; t < 12; t++) begin
      int d;
      int n;
      int npre;
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 3));
      npre = int'($urandom_range(0, 2));
      for (int k = 0; k < 4; k++) begin
        plan_rx[k] = 8'($urandom);
        plan_tx[k] = 8'($urandom);
        plan_ld[k] = 1'($urandom_range(0, 1));
      end
      for (int p = 0; p < npre; p++) do_load(d, 8'($urandom));
      xfer(d, n);
      $display("xfer %0d: dut%0d bytes=%0d last_rx=0x%02h", t, d, n, dout[d]);
    end

    wait_cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI peripheral (slave) endpoint, the receiving end of the `SPI_CLK`/`SPI_MOSI`/`SPI_MISO`/`SPI_EN` link driven by the SPI master driver. It oversamples the bus on the system clock, deserialises MOSI MSB-first into `data_out`, and serialises a pre-loaded transmit byte onto MISO. Bursts of several back-to-back bytes within one `SPI_EN` window are supported. CPOL and CPHA are parameters that must match the master.

## Interface
- CPOL, 0, SPI_CLK idle level.
- CPHA, 0, 0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- SPI_CLK  in  1  serial clock from master (asynchronous to clk).
- SPI_MOSI  in  1  serial data from master.
- SPI_EN  in  1  select, active-high, held for the whole transfer.
- SPI_MISO  out  1  serial data to master.
- data_in  in  8  transmit byte.
- tx_load  in  1  write `data_in` to the TX buffer; honoured only while `tx_ready`=1.
- tx_ready  out  1  TX buffer empty.
- data_out  out  8  last complete received byte.
- rx_valid  out  1  one-cycle pulse when `data_out` updates.
- tx_underrun  out  1  one-cycle pulse when a byte is started with an empty TX buffer.
- busy  out  1  state is ACTIVE.

## Operation
- Reset: the block is in IDLE. `SPI_MISO`=0, `data_out`=0x00, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `busy`=0. Synchronisers, counters and shifters are cleared.
- Synchronisers: `SPI_CLK`, `SPI_MOSI` and `SPI_EN` each pass through 2 flops. Edges are detected from the synced value against its previous value.
  - Leading edge: CPOL→!CPOL.
  - Trailing edge: the reverse.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- TX buffer: 8-bit register plus a `pending` flag; `tx_ready`=!pending.
  - `tx_load` while ready: capture `data_in`, set pending.
  - `tx_load` while not ready: ignored.
- Reload operation: `tx_shift` takes the buffer contents if pending (pending is cleared), else 0x00 with a `tx_underrun` pulse.
  - A same-cycle `tx_load` goes into the buffer after the reload samples it. That reload therefore underruns, and the new byte serves the next reload.
- `SPI_MISO` = `tx_shift[7]` in ACTIVE; 0 in IDLE.
- States:
  - IDLE: on synced `SPI_EN` rising: reload, bit_cnt=0, byte_done=0, go to ACTIVE. Clock edges are ignored in IDLE and in the select cycle.
  - ACTIVE, sample edge: `rx_shift` <= {`rx_shift`[6:0], synced MOSI}; bit_cnt++.
    - When bit_cnt was 7: `data_out` <= {`rx_shift`[6:0], MOSI}, `rx_valid` pulse, bit_cnt wraps to 0, byte_done=1.
  - ACTIVE, shift edge:
    - bit_cnt≠0: shift `tx_shift` left by one.
    - bit_cnt=0 and byte_done: reload, then clear byte_done.
    - Otherwise: hold.
  - ACTIVE, synced `SPI_EN` low: go to IDLE. The partial RX byte is discarded with no `rx_valid`; bit_cnt and byte_done are cleared. TX buffer/pending are unchanged.
- bit_cnt is 3 bits and wraps naturally. There are no other arithmetic paths.

## Timing
- Pin-to-action latency is 3 clk cycles: 2 sync stages plus the edge register. Registered outputs update on the 3rd clk edge after the pin change.
- `rx_valid` goes high 3 clk cycles after the 8th sample edge at the pin and lasts exactly 1 cycle. `data_out` is stable until the next completed byte.
- MISO changes 3 clk cycles after a shift edge or select assertion.
- Master constraints:
  - SPI_CLK high and low phases ≥ 4 clk cycles.
  - `SPI_EN` asserted ≥ 4 clk cycles before the first SPI_CLK edge.
  - `SPI_EN` deasserted ≥ 4 clk cycles after the last SPI_CLK edge.
- `tx_ready` falls the cycle after an accepted `tx_load`. It rises the cycle after a reload consumes the buffer.
- `rst` has priority over everything. It takes effect at the next clk edge, including mid-byte.

## Test plan
- CPOL=0/CPHA=0:
  - Stimulus: `tx_load` 0xA5, then master sends 0x3C.
  - Required: `data_out`=0x3C with a single `rx_valid` pulse; master samples MISO 1,0,1,0,0,1,0,1; `tx_ready` rises 3 cycles after select.
- Two-byte burst, one `SPI_EN` window:
  - Stimulus: 0xA5 preloaded, 0x5A loaded during byte 1; master sends 0x11, 0x22.
  - Required: two `rx_valid` pulses (0x11, 0x22); MISO 0xA5 then 0x5A; no `tx_underrun`.
- Empty TX buffer:
  - Stimulus: no `tx_load`; master sends 0xFF.
  - Required: MISO reads 0x00; `tx_underrun` pulses once at select; `data_out`=0xFF.
- Early deselect:
  - Stimulus: `SPI_EN` drops after 5 clocks.
  - Required: no `rx_valid`; `busy` falls; `data_out` unchanged. A following full transfer of 0x96 receives 0x96.
- CPOL=1/CPHA=1 instance:
  - Stimulus: `tx_load` 0xC3; master sends 0x81.
  - Required: `data_out`=0x81; master receives 0xC3.
- Mid-byte reset:
  - Stimulus: `rst` asserted after 3 bits.
  - Required: next cycle all outputs at reset values (`tx_ready`=1, `SPI_MISO`=0, `busy`=0); the next transfer after reset is correct.
